io_ctrl: RTL and testbench

- Parametrised memory-mapped I/O controller for the processor data bus; replaces the ad-hoc HEX/LEDR/LEDG/KEY/SW decode inside the core.
- Adds key synchronisation and debounce, sticky key-change status, and a prescaled programmable interval timer.
- Responds to the top 16 bytes of the address space: 8 word registers at byte addresses ...F0 to ...FE.

---
 rtl/io_ctrl_if.sv | 19 +
 rtl/io_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_io_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/io_ctrl_if.sv
// io_ctrl_if: processor data-bus connection to the memory-mapped I/O controller.
//   ADDR  byte address from the core
//   WE    write strobe
//   DIN   write data
//   DOUT  registered read data (1-cycle latency)
//   SEL   combinational window-hit indication
// master modport is the core side, slave modport is the controller side.
interface io_ctrl_if #(
    parameter int unsigned DBITS = 16
) ();
    logic [DBITS-1:0] ADDR;
    logic             WE;
    logic [DBITS-1:0] DIN;
    logic [DBITS-1:0] DOUT;
    logic             SEL;

    modport master (output ADDR, output WE, output DIN, input DOUT, input SEL);
    modport slave  (input ADDR, input WE, input DIN, output DOUT, output SEL);
endinterface

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped I/O controller occupying the top 16 bytes of the
// address space (8 word registers). Provides key sync/debounce, sticky
// key-change status, switch sync, seven-segment/LED output registers and a
// prescaled programmable interval timer.
// Optional feature macro: IO_IRQ_EN (adds IEN register and registered IRQ).
// Ports:
//   CLK, RESET  clock and asynchronous active-high reset
//   bus         io_ctrl_if.slave (ADDR, WE, DIN in; DOUT, SEL out)
//   KEY         raw active-low keys (asynchronous)
//   SW          raw switches (asynchronous)
//   HEX         active-low seven-segment outputs, digit 0 in LSBs
//   LEDR, LEDG  red/green LED outputs
//   IRQ         interrupt request (0 unless IO_IRQ_EN)
module io_ctrl #(
    parameter int unsigned DBITS    = 16,
    parameter int unsigned NDIGITS  = 4,
    parameter int unsigned NLEDR    = 10,
    parameter int unsigned NLEDG    = 8,
    parameter int unsigned NKEYS    = 4,
    parameter int unsigned NSW      = 10,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned DB_TICKS = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    io_ctrl_if.slave             bus,
    input  logic [NKEYS-1:0]     KEY,
    input  logic [NSW-1:0]       SW,
    output logic [7*NDIGITS-1:0] HEX,
    output logic [NLEDR-1:0]     LEDR,
    output logic [NLEDG-1:0]     LEDG,
    output logic                 IRQ
);

    localparam int unsigned SBITS = NKEYS + 2;
    localparam int unsigned HBITS = NDIGITS * 4;
    localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW    = $clog2(DB_TICKS + 1);
`ifdef IO_IRQ_EN
    localparam int unsigned TW    = DBITS - 1;
`else
    localparam int unsigned TW    = DBITS;
`endif

    localparam logic [2:0] OFF_KDATA  = 3'd0;
    localparam logic [2:0] OFF_SDATA  = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_TCNT   = 3'd3;
    localparam logic [2:0] OFF_HEXR   = 3'd4;
    localparam logic [2:0] OFF_LEDRR  = 3'd5;
    localparam logic [2:0] OFF_LEDGR  = 3'd6;
    localparam logic [2:0] OFF_TLIM   = 3'd7;

    // active-low segment pattern (gfedcba) for one hex nibble
    function automatic logic [6:0] seven_seg(input logic [3:0] nib);
        case (nib)
            4'h0: seven_seg = 7'b1000000;
            4'h1: seven_seg = 7'b1111001;
            4'h2: seven_seg = 7'b0100100;
            4'h3: seven_seg = 7'b0110000;
            4'h4: seven_seg = 7'b0011001;
            4'h5: seven_seg = 7'b0010010;
            4'h6: seven_seg = 7'b0000010;
            4'h7: seven_seg = 7'b1111000;
            4'h8: seven_seg = 7'b0000000;
            4'h9: seven_seg = 7'b0010000;
            4'hA: seven_seg = 7'b0001000;
            4'hB: seven_seg = 7'b0000011;
            4'hC: seven_seg = 7'b1000110;
            4'hD: seven_seg = 7'b0100001;
            4'hE: seven_seg = 7'b0000110;
            default: seven_seg = 7'b0001110;
        endcase
    endfunction

    logic [DBITS-1:0] dout_q,   dout_d;
    logic [HBITS-1:0] hexr_q,   hexr_d;
    logic [NLEDR-1:0] ledr_q,   ledr_d;
    logic [NLEDG-1:0] ledg_q,   ledg_d;
    logic [SBITS-1:0] status_q, status_d;
    logic [TW-1:0]    tcnt_q,   tcnt_d;
    logic [DBITS-1:0] tlim_q,   tlim_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic [NKEYS-1:0] key_s1_q, key_s1_d;
    logic [NKEYS-1:0] key_s2_q, key_s2_d;
    logic [NSW-1:0]   sw_s1_q,  sw_s1_d;
    logic [NSW-1:0]   sw_s2_q,  sw_s2_d;
    logic [NKEYS-1:0] deb_q,    deb_d;
    logic [CW-1:0]    cnt_q [NKEYS];
    logic [CW-1:0]    cnt_d [NKEYS];
`ifdef IO_IRQ_EN
    logic [SBITS-1:0] ien_q,    ien_d;
    logic             irq_q,    irq_d;
`endif

    logic             sel_c;
    logic             wr_c;
    logic [2:0]       off_c;
    logic             tick_c;
    logic [NKEYS-1:0] flip_c;
    logic             kovr_c;
    logic             twrap_c;
    logic             unused_addr0;

    assign sel_c        = &bus.ADDR[DBITS-1:4];
    assign off_c        = bus.ADDR[3:1];
    assign wr_c         = bus.WE && sel_c;
    assign tick_c       = (presc_q == PW'(TICK_DIV - 1));
    assign unused_addr0 = bus.ADDR[0];

    assign bus.SEL  = sel_c;
    assign bus.DOUT = dout_q;
    assign LEDR     = ledr_q;
    assign LEDG     = ledg_q;

    // next-state logic for all registers
    always_comb begin
        dout_d   = dout_q;
        hexr_d   = hexr_q;
        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        status_d = status_q;
        tcnt_d   = tcnt_q;
        tlim_d   = tlim_q;
        presc_d  = presc_q;
        deb_d    = deb_q;
        cnt_d    = cnt_q;
        flip_c   = '0;
        twrap_c  = 1'b0;
`ifdef IO_IRQ_EN
        ien_d    = ien_q;
        irq_d    = |(status_q & ien_q);
`endif

        // two-stage synchronisers
        key_s1_d = KEY;
        key_s2_d = key_s1_q;
        sw_s1_d  = SW;
        sw_s2_d  = sw_s1_q;

        // free-running prescaler; tick is the wrap cycle
        presc_d = tick_c ? '0 : presc_q + PW'(1);

        // per-key debounce, evaluated only on ticks
        for (int i = 0; i < int'(NKEYS); i++) begin
            if (tick_c) begin
                if (key_s2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == CW'(DB_TICKS - 1)) begin
                        flip_c[i] = 1'b1;
                        deb_d[i]  = ~deb_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i]  = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
        kovr_c = |(flip_c & status_q[NKEYS-1:0]);

        // timer: register writes take priority over tick increment
        if (wr_c && off_c == OFF_TLIM) begin
            tlim_d = bus.DIN;
            tcnt_d = '0;
        end else if (wr_c && off_c == OFF_TCNT) begin
`ifdef IO_IRQ_EN
            if (bus.DIN[DBITS-1]) begin
                ien_d = bus.DIN[SBITS-1:0];
            end else begin
                tcnt_d = bus.DIN[TW-1:0];
            end
`else
            tcnt_d = bus.DIN;
`endif
        end else if (tick_c && tlim_q != '0) begin
            if (DBITS'(tcnt_q) >= tlim_q - DBITS'(1)) begin
                tcnt_d  = '0;
                twrap_c = 1'b1;
            end else begin
                tcnt_d  = tcnt_q + TW'(1);
            end
        end

        // status: write-0-to-clear, hardware set wins over clear
        if (wr_c && off_c == OFF_STATUS) begin
            status_d = status_q & bus.DIN[SBITS-1:0];
        end
        status_d = status_d | {twrap_c, kovr_c, flip_c};

        if (wr_c && off_c == OFF_HEXR)  hexr_d = bus.DIN[HBITS-1:0];
        if (wr_c && off_c == OFF_LEDRR) ledr_d = bus.DIN[NLEDR-1:0];
        if (wr_c && off_c == OFF_LEDGR) ledg_d = bus.DIN[NLEDG-1:0];

        // read mux from current register contents
        case (off_c)
            OFF_KDATA:  dout_d = DBITS'(deb_q);
            OFF_SDATA:  dout_d = DBITS'(sw_s2_q);
            OFF_STATUS: dout_d = DBITS'(status_q);
            OFF_TCNT:   dout_d = DBITS'(tcnt_q);
            OFF_HEXR:   dout_d = DBITS'(hexr_q);
            OFF_LEDRR:  dout_d = DBITS'(ledr_q);
            OFF_LEDGR:  dout_d = DBITS'(ledg_q);
            default:    dout_d = tlim_q;
        endcase
    end

    // state registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dout_q   <= '0;
            hexr_q   <= '0;
            ledr_q   <= '0;
            ledg_q   <= '0;
            status_q <= '0;
            tcnt_q   <= '0;
            tlim_q   <= '0;
            presc_q  <= '0;
            key_s1_q <= '1;
            key_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            deb_q    <= '1;
            for (int i = 0; i < int'(NKEYS); i++) cnt_q[i] <= '0;
`ifdef IO_IRQ_EN
            ien_q    <= '0;
            irq_q    <= 1'b0;
`endif
        end else begin
            dout_q   <= dout_d;
            hexr_q   <= hexr_d;
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            status_q <= status_d;
            tcnt_q   <= tcnt_d;
            tlim_q   <= tlim_d;
            presc_q  <= presc_d;
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            deb_q    <= deb_d;
            for (int i = 0; i < int'(NKEYS); i++) cnt_q[i] <= cnt_d[i];
`ifdef IO_IRQ_EN
            ien_q    <= ien_d;
            irq_q    <= irq_d;
`endif
        end
    end

`ifdef IO_IRQ_EN
    assign IRQ = irq_q;
`else
    assign IRQ = 1'b0;
`endif

    // seven-segment decode, combinational from HEXR
    always_comb begin
        HEX = '1;
        for (int d = 0; d < int'(NDIGITS); d++) begin
            HEX[d*7 +: 7] = seven_seg(hexr_q[d*4 +: 4]);
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed self-checking bench for io_ctrl (TICK_DIV=4, DB_TICKS=3).
module tb_io_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [27:0] HEX;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;
    logic        IRQ;

    int n_assert = 0;
    int n_fail   = 0;

    io_ctrl_if #(.DBITS(16)) bus ();

    io_ctrl #(
        .DBITS(16), .NDIGITS(4), .NLEDR(10), .NLEDG(8), .NKEYS(4), .NSW(10),
        .TICK_DIV(4), .DB_TICKS(3)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus), .KEY(KEY), .SW(SW),
        .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // write cycle: strobe is sampled at the posedge between the two negedges
    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge CLK);
        bus.ADDR = a; bus.DIN = d; bus.WE = 1'b1;
        @(negedge CLK);
        bus.WE = 1'b0;
    endtask

    // read cycle: DOUT sampled one negedge after ADDR is presented
    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        @(negedge CLK);
        bus.ADDR = a; bus.WE = 1'b0;
        @(negedge CLK);
        d = bus.DOUT;
    endtask

    localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};
    localparam logic [27:0] HEX_1A2F = {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110};

    logic [15:0] v;
    logic [15:0] prev;
    logic [15:0] exp_seq [3];
    int          nchg;
    int          last_c;

    initial begin
        RESET = 1'b1; KEY = 4'hF; SW = '0;
        bus.ADDR = '0; bus.WE = 1'b0; bus.DIN = '0;
        exp_seq[0] = 16'd1; exp_seq[1] = 16'd2; exp_seq[2] = 16'd0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // reset state
        chk("rst_dout", bus.DOUT, 16'h0000);
        chk("rst_hex", HEX, HEX_ZERO);
        chk("rst_ledr", LEDR, 10'h000);
        chk("rst_ledg", LEDG, 8'h00);
        chk("rst_irq", IRQ, 1'b0);
        chk("sel_low_addr", bus.SEL, 1'b0);
        rd(16'hFFF8, v); chk("rst_hexr", v, 16'h0000);
        rd(16'hFFFA, v); chk("rst_ledrr", v, 16'h0000);
        rd(16'hFFFC, v); chk("rst_ledgr", v, 16'h0000);
        rd(16'hFFF4, v); chk("rst_status", v, 16'h0000);
        rd(16'hFFF0, v); chk("rst_kdata", v, 16'h000F);
        chk("sel_high_addr", bus.SEL, 1'b1);

        // HEXR write, read-after-write, decode; ADDR[0] ignored
        wr(16'hFFF8, 16'h1A2F);
        rd(16'hFFF8, v); chk("hexr_rd", v, 16'h1A2F);
        chk("hex_decode", HEX, HEX_1A2F);
        rd(16'hFFF9, v); chk("hexr_odd_addr", v, 16'h1A2F);

        // narrow registers zero-extend
        wr(16'hFFFA, 16'hFFFF);
        rd(16'hFFFA, v); chk("ledrr_zext", v, 16'h03FF);
        chk("ledr_port", LEDR, 10'h3FF);
        wr(16'hFFFC, 16'h12A5);
        rd(16'hFFFC, v); chk("ledgr_zext", v, 16'h00A5);
        chk("ledg_port", LEDG, 8'hA5);

        // short KEY[1] glitch (at most 2 ticks) is rejected
        @(negedge CLK); KEY = 4'b1101;
        repeat (6) @(negedge CLK);
        KEY = 4'hF;
        repeat (20) @(negedge CLK);
        rd(16'hFFF0, v); chk("glitch_kdata", v, 16'h000F);
        rd(16'hFFF4, v); chk("glitch_status", v, 16'h0000);

        // held KEY[1] flips the debounced value and sets KCHG[1]
        @(negedge CLK); KEY = 4'b1101;
        repeat (20) @(negedge CLK);
        rd(16'hFFF0, v); chk("press_kdata", v, 16'h000D);
        rd(16'hFFF4, v); chk("press_status", v, 16'h0002);

        // release flips again with KCHG still set -> KOVR
        @(negedge CLK); KEY = 4'hF;
        repeat (20) @(negedge CLK);
        rd(16'hFFF0, v); chk("release_kdata", v, 16'h000F);
        rd(16'hFFF4, v); chk("release_status", v, 16'h0012);
        wr(16'hFFF4, 16'hFFED);
        rd(16'hFFF4, v); chk("status_w0c", v, 16'h0000);

        // timer with TLIM=3: 0,1,2,0 on ticks, 4 cycles apart
        wr(16'hFFFE, 16'h0003);
        bus.ADDR = 16'hFFF6;
        prev = 16'h0000; nchg = 0; last_c = 0;
        for (int c = 0; c < 60 && nchg < 3; c++) begin
            @(negedge CLK);
            if (bus.DOUT !== prev) begin
                chk("tcnt_seq", bus.DOUT, exp_seq[nchg]);
                if (nchg > 0) chk("tcnt_gap", c - last_c, 4);
                last_c = c;
                prev   = bus.DOUT;
                nchg++;
            end
        end
        chk("tcnt_changes", nchg, 3);
        rd(16'hFFF4, v); chk("twrap_status", v, 16'h0020);

        // TLIM=0 freezes TCNT, including a software-loaded value
        wr(16'hFFFE, 16'h0000);
        wr(16'hFFF4, 16'hFFDF);
        rd(16'hFFF4, v); chk("twrap_clear", v, 16'h0000);
        wr(16'hFFF6, 16'h0005);
        repeat (12) @(negedge CLK);
        rd(16'hFFF6, v); chk("tcnt_frozen", v, 16'h0005);
        rd(16'hFFFE, v); chk("tlim_rd", v, 16'h0000);

        // switch path and read-only SDATA
        @(negedge CLK); SW = 10'h2A5;
        repeat (3) @(negedge CLK);
        rd(16'hFFF2, v); chk("sdata", v, 16'h02A5);
        wr(16'hFFF2, 16'h0000);
        rd(16'hFFF2, v); chk("sdata_ro", v, 16'h02A5);

        // out-of-window access
        @(negedge CLK); bus.ADDR = 16'h00F8;
        #1 chk("sel_outside", bus.SEL, 1'b0);
        wr(16'h00F8, 16'h1234);
        wr(16'hEFFA, 16'h0001);
        rd(16'hFFF8, v); chk("outside_no_hexr", v, 16'h1A2F);
        chk("outside_no_ledr", LEDR, 10'h3FF);
        chk("irq_default", IRQ, 1'b0);

        // asynchronous reset mid-operation
        @(negedge CLK); RESET = 1'b1;
        #1;
        chk("mid_rst_ledr", LEDR, 10'h000);
        chk("mid_rst_dout", bus.DOUT, 16'h0000);
        chk("mid_rst_hex", HEX, HEX_ZERO);
        @(negedge CLK); RESET = 1'b0;
        repeat (16) @(negedge CLK);
        rd(16'hFFF4, v); chk("post_rst_status", v, 16'h0000);
        rd(16'hFFF0, v); chk("post_rst_kdata", v, 16'h000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
